core_mem_responder: RTL and testbench
=====================================

Name: core_mem_responder

Overview:
- Memory-side responder for the core's instruction bus and data bus. It serves both word-addressed request/ack initiators from one internal single-port memory.
- Arbitrates between the two buses and inserts a configurable number of wait states.
- Returns a one-cycle ack for each request, with read data registered in the same cycle.
- Sits between the core and on-chip RAM. Used in FPGA builds and as the memory model in system benches.

Parameters:
ADDR_BITS, 12, number of word-address bits used; depth = 2^ADDR_BITS 16-bit words; upper address bits ignored (aliasing).
WAIT_STATES, 0, extra cycles inserted between grant and ack (0..15).

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
instr_m_addr  input  19  instruction word address [19:1]
instr_m_access  input  1  instruction request; held until ack
instr_m_ack  output  1  one-cycle ack for instruction request
instr_m_data_out  output  16  instruction read data, valid while instr_m_ack=1
data_m_addr  input  19  data word address [19:1]
data_m_data_in  input  16  write data from core
data_m_access  input  1  data request; held until ack
data_m_wr_en  input  1  1=write, 0=read
data_m_bytesel  input  2  byte enables; bit0=[7:0], bit1=[15:8]
data_m_ack  output  1  one-cycle ack for data request
data_m_data_out  output  16  data read data, valid while data_m_ack=1
busy  output  1  high in WAIT or ACK state

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE; all acks, both data outputs and busy forced to 0.
  - last_grant=INSTR, so data wins the first tie.
  - Memory contents are not cleared.
- Initiator rules:
  - access and addr (plus wr_en, bytesel, data_in for the data bus) stay stable from assertion until the cycle ack is seen.
  - An initiator may keep access high after ack to issue a new back-to-back request.
- State machine: IDLE, WAIT, ACK.
- IDLE:
  - If neither access is high, stay.
  - If exactly one access is high, grant it.
  - If both are high, grant the bus not in last_grant.
  - On grant, latch:
    - grant id;
    - addr[ADDR_BITS:1];
    - for data grants also wr_en, bytesel, data_in.
  - Set last_grant. Go to WAIT if WAIT_STATES>0, else ACK.
- WAIT:
  - Counter loaded with WAIT_STATES-1 on grant, decrements each cycle.
  - Go to ACK when the counter is 0.
- Transition into ACK (single edge):
  - Read: the granted bus's data_out is loaded with mem[latched addr].
  - Write: bytes with bytesel=1 are updated from the latched data. bytesel=00 writes nothing but is still acked. data_m_data_out is loaded with the pre-write word.
  - The granted bus's ack register goes to 1.
- ACK: lasts exactly one cycle.
  - Ack returns to 0 and state goes to IDLE.
  - data_out holds its value until the next ack on that bus.
- Latency: the request is sampled in IDLE at cycle t. Ack is high during cycle t+1+WAIT_STATES.
- Minimum back-to-back spacing: 2+WAIT_STATES cycles per access.
- Accesses are never issued on both buses in one grant; the other bus's ack stays 0.
- No starvation: with both buses continuously requesting, grants strictly alternate.
- Requests arriving during WAIT/ACK are not sampled until the following IDLE cycle.
- Reset during WAIT:
  - The pending access is dropped and no ack is issued.
  - A pending write is not performed.
- Reset on the ACK-entry edge takes priority; the write is not performed.
- Address aliasing: addr bits above ADDR_BITS are ignored.

Test Plan:
1. Write then read, WAIT_STATES=1: data write 0xBEEF to addr 0x00010 (bytesel=11) → data_m_ack high for exactly one cycle, 2 cycles after request. A subsequent read of 0x00010 returns data_m_data_out=0xBEEF in its ack cycle.
2. Byte enables, WAIT_STATES=0: over 0xBEEF at 0x00010, write 0x1234 with bytesel=10 → read gives 0x12EF. Then write 0x5678 with bytesel=01 → read gives 0x1278. bytesel=00 write → still acked, word unchanged.
3. Arbitration: after reset, raise instr read (addr 0x00010) and data read (addr 0x00010) in the same cycle. Result: data_m_ack first, then instr_m_ack one ACK later, both returning 0x1278. Hold both continuously for 8 accesses → acks strictly alternate, never both in one cycle.
4. Reset abort, WAIT_STATES=3: start data write 0xAAAA to 0x00020 (previously 0x0000). Pull reset low during the second WAIT cycle → no ack. Read of 0x00020 returns 0x0000. busy=0 the cycle after reset.
5. Aliasing, ADDR_BITS=10: write 0xCAFE to addr 0x00405 → read of addr 0x00005 returns 0xCAFE.
6. Instruction-only streaming, WAIT_STATES=0: instr_m_access held high for 4 consecutive requests → instr_m_ack pulses every 2 cycles. instr_m_data_out matches preloaded memory for each address.

Source files
------------

// File: rtl/core_mem_responder.sv
// core_mem_responder: serves the core's instruction and data request/ack buses
// from one single-port 16-bit word memory. Alternating-priority arbitration,
// WAIT_STATES extra cycles between grant and ack, one-cycle ack pulses.
module core_mem_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_out,
  input  logic [19:1] data_m_addr,
  input  logic [15:0] data_m_data_in,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;

  localparam int        DEPTH     = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit        NO_WAIT   = (WAIT_STATES == 0);

  logic [15:0]          r_mem [DEPTH];
  state_t               r_state;
  logic                 r_lastGrantData;
  logic                 r_grantData;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_wrEn;
  logic [1:0]           r_bytesel;
  logic [15:0]          r_wdata;
  logic [3:0]           r_waitCnt;
  logic                 r_instrAck;
  logic                 r_dataAck;
  logic [15:0]          r_instrDataOut;
  logic [15:0]          r_dataDataOut;
  logic                 r_busy;

  logic                 w_idle;
  logic                 w_pickData;
  logic                 w_grant;
  logic                 w_accData;
  logic [ADDR_BITS-1:0] w_accAddr;
  logic                 w_accWrite;
  logic [1:0]           w_accBytesel;
  logic [15:0]          w_accWdata;
  logic                 w_enterAck;
  logic                 w_unusedAddrBits;

  // Address bits above ADDR_BITS alias onto the same words and are dropped.
  assign w_unusedAddrBits = ^{instr_m_addr, data_m_addr};

  // Data wins a tie unless it was the last bus served, so grants alternate.
  assign w_idle     = (r_state == IDLE);
  assign w_pickData = data_m_access && (!instr_m_access || !r_lastGrantData);
  assign w_grant    = w_idle && (instr_m_access || data_m_access);

  // With zero wait states the access happens on the grant edge itself, so the
  // live bus fields are used in IDLE and the latched copy everywhere else.
  assign w_accData    = w_idle ? w_pickData : r_grantData;
  assign w_accAddr    = w_idle ? (w_pickData ? data_m_addr[ADDR_BITS:1]
                                             : instr_m_addr[ADDR_BITS:1])
                               : r_addr;
  assign w_accWrite   = w_idle ? (w_pickData && data_m_wr_en) : r_wrEn;
  assign w_accBytesel = w_idle ? data_m_bytesel : r_bytesel;
  assign w_accWdata   = w_idle ? data_m_data_in : r_wdata;
  assign w_enterAck   = (w_grant && NO_WAIT) || ((r_state == WAIT) && (r_waitCnt == 4'd0));

  // Byte-masked memory write on the ACK-entry edge; a reset on that edge wins.
  always_ff @(posedge clk) begin
    if (reset && w_enterAck && w_accData && w_accWrite) begin
      if (w_accBytesel[0]) r_mem[w_accAddr][7:0]  <= w_accWdata[7:0];
      if (w_accBytesel[1]) r_mem[w_accAddr][15:8] <= w_accWdata[15:8];
    end
  end

  // Arbitration/wait-state FSM with registered acks, read data and busy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_lastGrantData <= 1'b0;
      r_grantData     <= 1'b0;
      r_addr          <= '0;
      r_wrEn          <= 1'b0;
      r_bytesel       <= 2'b00;
      r_wdata         <= 16'h0000;
      r_waitCnt       <= 4'd0;
      r_instrAck      <= 1'b0;
      r_dataAck       <= 1'b0;
      r_instrDataOut  <= 16'h0000;
      r_dataDataOut   <= 16'h0000;
      r_busy          <= 1'b0;
    end else begin
      r_instrAck <= 1'b0;
      r_dataAck  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_grantData     <= w_pickData;
            r_lastGrantData <= w_pickData;
            r_addr          <= w_accAddr;
            r_wrEn          <= w_accWrite;
            r_bytesel       <= w_accBytesel;
            r_wdata         <= w_accWdata;
            r_waitCnt       <= WAIT_LOAD;
            r_busy          <= 1'b1;
            r_state         <= NO_WAIT ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (r_waitCnt == 4'd0) begin
            r_state <= ACK;
          end else begin
            r_waitCnt <= r_waitCnt - 4'd1;
          end
        end
        ACK: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (w_enterAck) begin
        if (w_accData) begin
          r_dataAck     <= 1'b1;
          r_dataDataOut <= r_mem[w_accAddr];
        end else begin
          r_instrAck     <= 1'b1;
          r_instrDataOut <= r_mem[w_accAddr];
        end
      end
    end
  end

  assign instr_m_ack      = r_instrAck;
  assign instr_m_data_out = r_instrDataOut;
  assign data_m_ack       = r_dataAck;
  assign data_m_data_out  = r_dataDataOut;
  assign busy             = r_busy;

endmodule

// File: tb/tb_core_mem_responder.sv
// tb_core_mem_responder: three responder instances with different wait-state
// and address-width settings, driven by directed vectors. Expected acks are
// queued when a request is issued and popped by an independent monitor.
module tb_core_mem_responder;

  localparam int NI = 3;

  logic clk = 1'b0;
  int   cyc = 0;
  int   vecCount = 0;
  int   missCount = 0;

  logic        rstN   [NI];
  logic [19:1] iAddr  [NI];
  logic        iAcc   [NI];
  logic        iAck   [NI];
  logic [15:0] iDout  [NI];
  logic [19:1] dAddr  [NI];
  logic [15:0] dDin   [NI];
  logic        dAcc   [NI];
  logic        dWr    [NI];
  logic [1:0]  dBs    [NI];
  logic        dAck   [NI];
  logic [15:0] dDout  [NI];
  logic        busyS  [NI];

  typedef struct {
    int          inst;
    bit          isData;
    logic [15:0] data;
    bit          chkData;
    int          cyc;
  } exp_t;

  exp_t sbQ[$];

  // Free-running clock and a posedge counter used for latency expectations.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: WAIT_STATES=1; instance 1: WAIT_STATES=0, ADDR_BITS=10; instance 2: WAIT_STATES=3.
  for (genvar g = 0; g < NI; g++) begin : gDut
    core_mem_responder #(
      .ADDR_BITS  ((g == 1) ? 10 : 12),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) dut (
      .clk             (clk),
      .reset           (rstN[g]),
      .instr_m_addr    (iAddr[g]),
      .instr_m_access  (iAcc[g]),
      .instr_m_ack     (iAck[g]),
      .instr_m_data_out(iDout[g]),
      .data_m_addr     (dAddr[g]),
      .data_m_data_in  (dDin[g]),
      .data_m_access   (dAcc[g]),
      .data_m_wr_en    (dWr[g]),
      .data_m_bytesel  (dBs[g]),
      .data_m_ack      (dAck[g]),
      .data_m_data_out (dDout[g]),
      .busy            (busyS[g])
    );
  end

  function automatic int wsOf(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vecCount++;
    if (act !== req) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic pushExp(input int k, input bit isData, input logic [15:0] data,
                         input bit chk, input int ackCyc);
    exp_t e;
    e.inst = k; e.isData = isData; e.data = data; e.chkData = chk; e.cyc = ackCyc;
    sbQ.push_back(e);
  endtask

  // Monitor: every ack is matched against the head of the scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (iAck[k] === 1'b1 && dAck[k] === 1'b1) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL dual ack on instance %0d: got both acks, expected one", k);
      end else if (iAck[k] === 1'b1 || dAck[k] === 1'b1) begin
        if (sbQ.size() == 0) begin
          vecCount++;
          missCount++;
          $display("[TB] FAIL unexpected ack on instance %0d: got ack, expected none (cycle %0d)", k, cyc);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("ack instance", k, e.inst);
          checkOutput("ack bus (1=data)", {31'd0, dAck[k]}, {31'd0, e.isData});
          if (e.chkData)
            checkOutput("ack read data", dAck[k] ? dDout[k] : iDout[k], e.data);
          checkOutput("ack cycle", cyc, e.cyc);
        end
      end
    end
  end

  // One request on one bus, held until its ack is seen (bounded).
  task automatic applyStimulus(input int k, input bit isData, input logic [19:1] addr,
                               input bit wr, input logic [1:0] bs, input logic [15:0] din,
                               input bit chk, input logic [15:0] expData);
    bit got;
    got = 1'b0;
    @(negedge clk);
    if (isData) begin
      dAddr[k] = addr; dWr[k] = wr; dBs[k] = bs; dDin[k] = din; dAcc[k] = 1'b1;
    end else begin
      iAddr[k] = addr; iAcc[k] = 1'b1;
    end
    pushExp(k, isData, expData, chk, cyc + 1 + wsOf(k));
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((isData ? dAck[k] : iAck[k]) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    dAcc[k] = 1'b0;
    iAcc[k] = 1'b0;
    if (!got) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL ack timeout on instance %0d: got no ack, expected one", k);
      sbQ.delete();
    end
  endtask

  task automatic applyReset(input int k);
    @(negedge clk);
    rstN[k] = 1'b0; iAcc[k] = 1'b0; dAcc[k] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstN[k] = 1'b1;
  endtask

  task automatic checkResetState(input int k);
    checkOutput("reset instr ack", {31'd0, iAck[k]}, 32'd0);
    checkOutput("reset data ack", {31'd0, dAck[k]}, 32'd0);
    checkOutput("reset instr data_out", {16'd0, iDout[k]}, 32'd0);
    checkOutput("reset data data_out", {16'd0, dDout[k]}, 32'd0);
    checkOutput("reset busy", {31'd0, busyS[k]}, 32'd0);
  endtask

  initial begin
    int n0;
    int dCnt;
    int iCnt;
    for (int k = 0; k < NI; k++) begin
      rstN[k] = 1'b0; iAddr[k] = '0; iAcc[k] = 1'b0; dAddr[k] = '0; dDin[k] = '0;
      dAcc[k] = 1'b0; dWr[k] = 1'b0; dBs[k] = 2'b00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) rstN[k] = 1'b1;
    for (int k = 0; k < NI; k++) checkResetState(k);

    // Write then read with one wait state, plus a read on the instruction bus.
    applyStimulus(0, 1'b1, 19'h00010, 1'b1, 2'b11, 16'hBEEF, 1'b0, 16'h0000);
    applyStimulus(0, 1'b1, 19'h00010, 1'b0, 2'b11, 16'h0000, 1'b1, 16'hBEEF);
    applyStimulus(0, 1'b0, 19'h00010, 1'b0, 2'b00, 16'h0000, 1'b1, 16'hBEEF);

    // Byte enables with zero wait states; write acks return the pre-write word.
    applyStimulus(1, 1'b1, 19'h00010, 1'b1, 2'b11, 16'hBEEF, 1'b0, 16'h0000);
    applyStimulus(1, 1'b1, 19'h00010, 1'b1, 2'b10, 16'h1234, 1'b1, 16'hBEEF);
    applyStimulus(1, 1'b1, 19'h00010, 1'b0, 2'b11, 16'h0000, 1'b1, 16'h12EF);
    applyStimulus(1, 1'b1, 19'h00010, 1'b1, 2'b01, 16'h5678, 1'b1, 16'h12EF);
    applyStimulus(1, 1'b1, 19'h00010, 1'b0, 2'b11, 16'h0000, 1'b1, 16'h1278);
    applyStimulus(1, 1'b1, 19'h00010, 1'b1, 2'b00, 16'hFFFF, 1'b1, 16'h1278);
    applyStimulus(1, 1'b1, 19'h00010, 1'b0, 2'b11, 16'h0000, 1'b1, 16'h1278);

    // Arbitration after reset: data wins the tie, then strict alternation.
    applyReset(1);
    checkResetState(1);
    @(negedge clk);
    iAddr[1] = 19'h00010; iAcc[1] = 1'b1;
    dAddr[1] = 19'h00010; dWr[1] = 1'b0; dBs[1] = 2'b11; dAcc[1] = 1'b1;
    n0 = cyc;
    for (int j = 0; j < 4; j++) begin
      pushExp(1, 1'b1, 16'h1278, 1'b1, n0 + 1 + 4 * j);
      pushExp(1, 1'b0, 16'h1278, 1'b1, n0 + 3 + 4 * j);
    end
    dCnt = 0; iCnt = 0;
    for (int n = 0; n < 24 && (dCnt < 4 || iCnt < 4); n++) begin
      @(negedge clk);
      if (dAck[1] === 1'b1) dCnt++;
      if (iAck[1] === 1'b1) iCnt++;
      if (dCnt >= 4) dAcc[1] = 1'b0;
      if (iCnt >= 4) iAcc[1] = 1'b0;
    end
    dAcc[1] = 1'b0; iAcc[1] = 1'b0;
    checkOutput("alternating data ack count", dCnt, 4);
    checkOutput("alternating instr ack count", iCnt, 4);

    // Address aliasing with ADDR_BITS=10.
    applyStimulus(1, 1'b1, 19'h00405, 1'b1, 2'b11, 16'hCAFE, 1'b0, 16'h0000);
    applyStimulus(1, 1'b1, 19'h00005, 1'b0, 2'b11, 16'h0000, 1'b1, 16'hCAFE);

    // Instruction streaming with access held high across four requests.
    applyStimulus(1, 1'b1, 19'h00020, 1'b1, 2'b11, 16'h1111, 1'b0, 16'h0000);
    applyStimulus(1, 1'b1, 19'h00021, 1'b1, 2'b11, 16'h2222, 1'b0, 16'h0000);
    applyStimulus(1, 1'b1, 19'h00022, 1'b1, 2'b11, 16'h3333, 1'b0, 16'h0000);
    applyStimulus(1, 1'b1, 19'h00023, 1'b1, 2'b11, 16'h4444, 1'b0, 16'h0000);
    @(negedge clk);
    iAddr[1] = 19'h00020; iAcc[1] = 1'b1;
    n0 = cyc;
    pushExp(1, 1'b0, 16'h1111, 1'b1, n0 + 1);
    pushExp(1, 1'b0, 16'h2222, 1'b1, n0 + 3);
    pushExp(1, 1'b0, 16'h3333, 1'b1, n0 + 5);
    pushExp(1, 1'b0, 16'h4444, 1'b1, n0 + 7);
    iCnt = 0;
    for (int n = 0; n < 20 && iCnt < 4; n++) begin
      @(negedge clk);
      if (iAck[1] === 1'b1) begin
        iCnt++;
        iAddr[1] = 19'h00020 + 19'(iCnt);
      end
    end
    iAcc[1] = 1'b0;
    checkOutput("streaming instr ack count", iCnt, 4);

    // Reset during the second wait cycle drops a pending write (three wait states).
    applyStimulus(2, 1'b1, 19'h00020, 1'b1, 2'b11, 16'h0000, 1'b0, 16'h0000);
    @(negedge clk);
    dAddr[2] = 19'h00020; dWr[2] = 1'b1; dBs[2] = 2'b11; dDin[2] = 16'hAAAA; dAcc[2] = 1'b1;
    @(negedge clk);
    checkOutput("busy in wait", {31'd0, busyS[2]}, 32'd1);
    @(negedge clk);
    rstN[2] = 1'b0; dAcc[2] = 1'b0;
    @(negedge clk);
    rstN[2] = 1'b1;
    checkOutput("busy after reset", {31'd0, busyS[2]}, 32'd0);
    checkOutput("no ack after reset", {31'd0, dAck[2]}, 32'd0);
    repeat (6) @(negedge clk);
    applyStimulus(2, 1'b1, 19'h00020, 1'b0, 2'b11, 16'h0000, 1'b1, 16'h0000);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard drained", sbQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  // Global time limit so the bench cannot hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
